// File: rtl/riscv_lsu.sv
// riscv_lsu: memory-stage load/store unit with a request/ack data bus.
// Define RISCV_LSU_MISALIGN_EN to split misaligned accesses into two bus beats; otherwise they fault.
module riscv_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_misalign
);

`ifdef RISCV_LSU_MISALIGN_EN
    typedef enum logic [1:0] {IDLE, BUS0, BUS1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUS0, RESP} state_t;
`endif

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  sz_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic [1:0]  off;
    logic        misalign;
    logic [3:0]  mask;
    logic [63:0] ld_raw;
    logic [31:0] ld_data;

    assign off       = req_addr[1:0];
    assign misalign  = (req_funct3[1:0] == 2'b01 && off == 2'b11) || (req_funct3[1] && off != 2'b00);
    assign mask      = (req_funct3[1:0] == 2'b00) ? 4'h1 : (req_funct3[1:0] == 2'b01) ? 4'h3 : 4'hF;
    assign req_ready = (state == IDLE);

    function automatic logic [31:0] load_ext(input logic [63:0] raw, input logic [1:0] o,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = 32'(raw >> {o, 3'b000});
        case (sz)
            2'b00:   load_ext = uns ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   load_ext = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

`ifdef RISCV_LSU_MISALIGN_EN
    logic        mis_q;
    logic [31:0] lo;
    logic [31:0] wdata_hi;
    logic [3:0]  strb_hi;
    logic [63:0] wvec;
    logic [7:0]  svec;

    assign wvec   = {32'b0, req_wdata} << {off, 3'b000};
    assign svec   = {4'b0, mask} << off;
    assign ld_raw = (state == BUS1) ? {mem_rdata, lo} : {32'b0, mem_rdata};
`else
    logic [31:0] wvec;
    logic [3:0]  svec;

    assign wvec   = req_wdata << {off, 3'b000};
    assign svec   = mask << off;
    assign ld_raw = {32'b0, mem_rdata};
`endif

    assign ld_data = we_q ? 32'b0 : load_ext(ld_raw, off_q, sz_q, uns_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            sz_q         <= 2'b00;
            off_q        <= 2'b00;
            rd_q         <= 5'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'b0;
            mem_wdata    <= 32'b0;
            mem_wstrb    <= 4'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'b0;
            rsp_rd       <= 5'd0;
            rsp_misalign <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_EN
            mis_q        <= 1'b0;
            lo           <= 32'b0;
            wdata_hi     <= 32'b0;
            strb_hi      <= 4'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    we_q  <= req_write;
                    uns_q <= req_funct3[2];
                    sz_q  <= req_funct3[1:0];
                    off_q <= off;
                    rd_q  <= req_rd;
`ifdef RISCV_LSU_MISALIGN_EN
                    mis_q    <= misalign;
                    wdata_hi <= wvec[63:32];
                    strb_hi  <= req_write ? svec[7:4] : 4'b0;
                    if (1'b1) begin
`else
                    if (misalign) begin
                        // Fault without touching the bus.
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= 32'b0;
                        rsp_rd       <= req_rd;
                        rsp_misalign <= 1'b1;
                    end else begin
`endif
                        state     <= BUS0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_write;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wvec[31:0];
                        mem_wstrb <= req_write ? svec[3:0] : 4'b0;
                    end
                end
                BUS0: if (mem_req && mem_ack) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'b0;
`ifdef RISCV_LSU_MISALIGN_EN
                    if (mis_q) begin
                        state <= BUS1;
                        lo    <= mem_rdata;
                    end else begin
`else
                    begin
`endif
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= ld_data;
                        rsp_rd       <= rd_q;
                        rsp_misalign <= 1'b0;
                    end
                end
`ifdef RISCV_LSU_MISALIGN_EN
                // Entered with mem_req low: that cycle is the idle gap before beat two.
                BUS1: if (!mem_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= we_q;
                    mem_addr  <= mem_addr + 32'd4;
                    mem_wdata <= wdata_hi;
                    mem_wstrb <= strb_hi;
                end else if (mem_ack) begin
                    mem_req      <= 1'b0;
                    mem_we       <= 1'b0;
                    mem_wstrb    <= 4'b0;
                    state        <= RESP;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= ld_data;
                    rsp_rd       <= rd_q;
                    rsp_misalign <= 1'b0;
                end
`endif
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu; follows RISCV_LSU_MISALIGN_EN for the split-access case.
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_misalign;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_misalign(rsp_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // One aligned access: bus fields checked on every request cycle, response checked after ack.
    task automatic single(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                          input int waits, input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_rsp);
        issue(w, f3, a, wd, rd);
        for (int i = 0; i <= waits; i++) begin
            chk({tag, ".req"},   32'(mem_req), 32'd1);
            chk({tag, ".we"},    32'(mem_we), 32'(w));
            chk({tag, ".addr"},  mem_addr, e_addr);
            chk({tag, ".strb"},  32'(mem_wstrb), 32'(e_strb));
            if (w) chk({tag, ".wdata"}, mem_wdata, e_wdata);
            chk({tag, ".rspv_early"}, 32'(rsp_valid), 32'd0);
            if (i < waits) tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        chk({tag, ".rspv"},  32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, e_rsp);
        chk({tag, ".rd"},    32'(rsp_rd), 32'(rd));
        chk({tag, ".mis"},   32'(rsp_misalign), 32'd0);
        chk({tag, ".reqlo"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".hold"},  rsp_rdata, e_rsp);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0; req_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'b0;
        tick();
        tick();
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.req",   32'(mem_req), 32'd0);
        chk("rst.addr",  mem_addr, 32'd0);
        chk("rst.strb",  32'(mem_wstrb), 32'd0);
        chk("rst.rspv",  32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.mis",   32'(rsp_misalign), 32'd0);
        rst = 1'b0;
        tick();

        single("lw",  1'b0, 3'b010, 32'h100, 32'h0, 5'd5,  32'hDEADBEEF, 0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
        single("lb",  1'b0, 3'b000, 32'h103, 32'h0, 5'd6,  32'h80FF1234, 0, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80);
        single("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 5'd7,  32'h80FF1234, 0, 32'h100, 4'h0, 32'h0, 32'h00000080);
        single("lh",  1'b0, 3'b001, 32'h101, 32'h0, 5'd8,  32'h80FF1234, 1, 32'h100, 4'h0, 32'h0, 32'hFFFFFF12);
        single("lhu", 1'b0, 3'b101, 32'h101, 32'h0, 5'd9,  32'h80FF1234, 0, 32'h100, 4'h0, 32'h0, 32'h0000FF12);
        single("sh",  1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd10, 32'h0, 3, 32'h100, 4'hC, 32'hABCD0000, 32'h0);
        single("sb",  1'b1, 3'b000, 32'h201, 32'h12345678, 5'd11, 32'h0, 0, 32'h200, 4'h2, 32'h34567800, 32'h0);
        single("lw2", 1'b0, 3'b010, 32'h204, 32'h0, 5'd12, 32'h0000AA55, 0, 32'h204, 4'h0, 32'h0, 32'h0000AA55);

        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd13);
`ifdef RISCV_LSU_MISALIGN_EN
        chk("mis.req0",  32'(mem_req), 32'd1);
        chk("mis.addr0", mem_addr, 32'hFFFFFFFC);
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_ack = 1'b0;
        chk("mis.gap",   32'(mem_req), 32'd0);
        chk("mis.rspv0", 32'(rsp_valid), 32'd0);
        tick();
        chk("mis.req1",  32'(mem_req), 32'd1);
        chk("mis.addr1", mem_addr, 32'h00000000);
        mem_ack = 1'b1; mem_rdata = 32'h55667788;
        tick();
        mem_ack = 1'b0;
        chk("mis.rspv",  32'(rsp_valid), 32'd1);
        chk("mis.rdata", rsp_rdata, 32'h77881122);
        chk("mis.flag",  32'(rsp_misalign), 32'd0);
        chk("mis.rd",    32'(rsp_rd), 32'd13);
`else
        chk("mis.rspv",  32'(rsp_valid), 32'd1);
        chk("mis.req",   32'(mem_req), 32'd0);
        chk("mis.flag",  32'(rsp_misalign), 32'd1);
        chk("mis.rdata", rsp_rdata, 32'd0);
        chk("mis.rd",    32'(rsp_rd), 32'd13);
`endif
        tick();
        chk("mis.ready", 32'(req_ready), 32'd1);
        chk("mis.pulse", 32'(rsp_valid), 32'd0);

        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd14);
        chk("rstmid.req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.reqlo", 32'(mem_req), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.rdata", rsp_rdata, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        chk("rstmid.late0", 32'(rsp_valid), 32'd0);
        tick();
        chk("rstmid.late1", 32'(rsp_valid), 32'd0);

        single("post", 1'b0, 3'b010, 32'h400, 32'h0, 5'd15, 32'hCAFEF00D, 0, 32'h400, 4'h0, 32'h0, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
